arb_requester: RTL

ARB_REQUESTER -- requirements
Module: arb_requester

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_requester.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the burst requester: FSM state encoding and default sizing.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  localparam int ARB_LEN_WIDTH      = 4;
  localparam int ARB_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/arb_requester.sv
// Burst requester in front of a locking arbiter: holds req_out for a whole burst.
// Optional grant-wait timeout compiled in with ARB_REQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a command, req_out low
// REQ   | requesting, waiting for grant_in
// XFER  | granted, one beat per cycle while grant_in holds
// DRAIN | req_out released, waiting for grant_in to fall
module arb_requester
  import arb_pkg::*;
#(
  parameter int LEN_WIDTH      = ARB_LEN_WIDTH,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_in,
  input  logic                 cmd_valid_in,
  input  logic [LEN_WIDTH-1:0] cmd_len_in,
  output logic                 cmd_ready_out,
  output logic                 req_out,
  input  logic                 grant_in,
  output logic                 beat_out,
  output logic [LEN_WIDTH-1:0] beat_idx_out,
  output logic                 done_out,
  output logic                 timeout_out,
  output logic                 error_out
);

  arb_state_e           state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_idx_q;
  logic                 error_q;
  logic                 abort_q;
  logic                 done_q;
  logic                 cmd_fire;
  logic                 last_beat;
  logic                 grant_lost;
  logic                 wait_expired;

  assign cmd_fire   = (state == IDLE) && cmd_valid_in && !init_in;
  assign last_beat  = (beat_idx_q == len_q);
  assign grant_lost = (state == XFER) && !grant_in;

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WAIT_W-1:0] wait_cnt_q;
  logic              timeout_q;

  assign wait_expired = (state == REQ) && (wait_cnt_q == '0);

  // Down-counter loaded on the handshake; terminal count is the last REQ cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= wait_expired && !grant_in && !init_in;
      if (cmd_fire) begin
        wait_cnt_q <= WAIT_W'(TIMEOUT_CYCLES - 1);
      end else if ((state == REQ) && (wait_cnt_q != '0)) begin
        wait_cnt_q <= wait_cnt_q - 1'b1;
      end
    end
  end

  assign timeout_out = timeout_q;
`else
  // TIMEOUT_CYCLES stays in the port map so both builds share one instantiation.
  localparam logic TIMEOUT_TIE = 1'b0 && (TIMEOUT_CYCLES > 0);

  assign wait_expired = 1'b0;
  assign timeout_out  = TIMEOUT_TIE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (init_in) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (cmd_valid_in) state_nxt = REQ;
        REQ: begin
          if (grant_in)          state_nxt = XFER;
          else if (wait_expired) state_nxt = IDLE;
        end
        XFER:  if (!grant_in || last_beat) state_nxt = DRAIN;
        DRAIN: if (!grant_in) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // abort_q suppresses done_out for a burst that lost its grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      beat_idx_q <= '0;
      error_q    <= 1'b0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == DRAIN) && !grant_in && !abort_q && !init_in;
      if (init_in) begin
        beat_idx_q <= '0;
        error_q    <= 1'b0;
        abort_q    <= 1'b0;
      end else begin
        if (cmd_fire) begin
          len_q      <= cmd_len_in;
          beat_idx_q <= '0;
          abort_q    <= 1'b0;
        end
        if ((state == XFER) && grant_in && !last_beat) begin
          beat_idx_q <= beat_idx_q + 1'b1;
        end
        if (grant_lost) begin
          error_q <= 1'b1;
          abort_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    cmd_ready_out = 1'b0;
    req_out       = 1'b0;
    beat_out      = 1'b0;
    unique case (state)
      IDLE:  cmd_ready_out = !init_in;
      REQ:   req_out = 1'b1;
      XFER: begin
        req_out  = 1'b1;
        beat_out = grant_in && !init_in;
      end
      DRAIN: req_out = 1'b0;
      default: ;
    endcase
  end

  assign beat_idx_out = beat_idx_q;
  assign done_out     = done_q;
  assign error_out    = error_q;

endmodule
